axi4_stream_pkt_merge: RTL and testbench
========================================

// Module: axi4_stream_pkt_merge
// PURPOSE
//  Receive-side counterpart of the packet splitter. Concatenates consecutive short AXI4-Stream input packets into longer output packets.
//  Output packet closes once its byte count reaches flush_thresh_i, on a tid/tdest change, or after timeout_i idle cycles.
//  Byte-packed: gaps from partial last beats are removed; only the output tlast beat may be partial.
// PARAMETERS
//  DATA_WIDTH      32                       tdata width, bits (multiple of 8); W = DATA_WIDTH/8 bytes
//  ID_WIDTH        1                        tid width
//  DEST_WIDTH      1                        tdest width
//  USER_WIDTH      1                        tuser width
//  MAX_PKT_SIZE_B  2048                     largest flush threshold, bytes
//  PKT_SIZE_WIDTH  $clog2(MAX_PKT_SIZE_B)   byte-counter width
//  TIMEOUT_WIDTH   16                       idle-counter width
// PORTS
//  clk_i           in   1                   clock
//  rst_n_i         in   1                   reset, asynchronous, active-low
//  flush_thresh_i  in   PKT_SIZE_WIDTH+1    close output packet at input tlast once out bytes >= this (1..MAX_PKT_SIZE_B)
//  timeout_i       in   TIMEOUT_WIDTH       idle cycles before an open packet is force-closed; 0 = timeout disabled
//  pkt_i           axi4_stream_if slave     input packets; tkeep contiguous from byte 0, partial only on tlast beat
//  pkt_o           axi4_stream_if master    merged packets
// BEHAVIOUR
//  Reset: state=IDLE, all counters 0, hold/residue invalid. pkt_o.tvalid=0, tlast=0, tdata/tkeep/tstrb/tid/tdest/tuser=0.
//  Storage: hold reg H (one full word + tlast-less), residue R (res_cnt 0..W-1 bytes), out_bytes, idle_cnt.
//  Packing on each accepted beat with n valid bytes: C = R | (in << 8*res_cnt), total = res_cnt + n.
//   - total >= W: low W bytes form full word F. If H valid, H is presented on pkt_o (tlast=0). H <= F. R <= upper total-W bytes.
//   - total < W: R <= C, res_cnt <= total.
//   - tstrb packed identically to tkeep. tid/tdest/tuser latched from first beat of each output packet.
//  Handshake: pkt_i.tready = (state==MERGE||IDLE) && (!H_valid || pkt_o.tready) && !id_change. pkt_o.tvalid only carries H or flush words.
//  Words never leave before the next word is known, so tlast always lands on a real data beat.
//  Latency: first byte out >= 2 cycles after its input beat; no combinational path from pkt_i to pkt_o.
//  out_bytes += n per accepted beat (saturate at 2^(PKT_SIZE_WIDTH+1)-1); cleared when output tlast handshakes.
//  FSM:
//   IDLE   no open packet. First accepted beat -> MERGE (latch tid/tdest/tuser).
//   MERGE  packet open.
//          - At accepted input tlast with out_bytes(after add) >= flush_thresh_i -> FLUSH.
//          - Between input packets: pkt_i.tvalid with tid/tdest != latched -> id_change, beat not accepted, -> FLUSH.
//          - Between input packets: idle_cnt == timeout_i (timeout_i!=0) -> FLUSH.
//          - idle_cnt counts cycles with no accepted beat after an input tlast; reset on any accepted beat.
//          - Mid-input-packet (no tlast yet) never closes; timeout frozen.
//   FLUSH  pkt_i.tready=0.
//          - Emit H (tlast=1 iff res_cnt==0), then R if res_cnt>0 (tkeep = low res_cnt bits, tlast=1).
//          - Each beat waits for pkt_o.tready; tvalid/data stable while stalled.
//          - After tlast handshake -> IDLE; pending id_change beat then accepted normally.
//  Edge cases:
//   - total == W exactly at closing tlast: H gets F, res_cnt=0, single tlast beat.
//   - Single-beat packet exceeding threshold alone: flushed as-is.
//   - Output packets may exceed flush_thresh_i by at most one input packet; input packets never split.
//   - flush_thresh_i sampled each cycle; change only while IDLE.
//   - Async reset mid-packet discards H/R without emitting tlast.
// STRUCTURE
//  Package axi4_stream_merge_pkg: state enum (IDLE, MERGE, FLUSH), byte-count function popcount_keep(), W/BYTE_CNT_WIDTH localparams.
//  Sub-module axi4_stream_byte_packer: combinational residue+input shift/merge producing F, new R, total.
//  FSM, counters, H register and port mapping live in the top.
// TESTING
//  1) W=4, thresh=16, four 4-byte packets back-to-back -> one 16-byte output packet, 4 beats, tkeep=F, tlast on beat 4.
//  2) W=4, thresh=8, packets of 3,3,3 bytes -> one 9-byte packet: beats tkeep F,F,1 with bytes contiguous in order.
//  3) Packet tid=0 (5 B), then tid=1 (2 B), thresh=64 -> tid=0 packet of 5 B closed before tid=1 beat accepted; tid=1 closes by timeout.
//  4) timeout_i=10, single 6-byte packet, thresh=64, then idle -> tlast beat with 6 bytes appears 10 idle cycles after input tlast (+fixed pipeline).
//  5) Random pkt_o.tready (50%) with threshold 32 over 1000 random packets 1..40 B -> byte stream identical to input, no packet < 32 B except timeout/id closes.
//  6) Assert rst_n_i low mid-FLUSH -> pkt_o.tvalid=0 same cycle; next input starts new packet with out_bytes=0.

Source files
------------

// File: rtl/axi4_stream_merge_pkg.sv
// Shared types and helpers for the AXI4-Stream packet merger.
// W/BYTE_CNT_WIDTH describe the default 32-bit datapath; modules derive their own from DATA_WIDTH.
package axi4_stream_merge_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMerge,
        StFlush
    } state_e;

    localparam int unsigned W              = 4;
    localparam int unsigned BYTE_CNT_WIDTH = $clog2(W) + 1;
    localparam int unsigned KEEP_MAX       = 64;

    // tkeep is contiguous from byte 0, so a popcount is the beat's byte count.
    function automatic logic [7:0] popcount_keep(input logic [KEEP_MAX-1:0] keep);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            cnt = cnt + {7'd0, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views.
interface axi4_stream_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DEST_WIDTH = 1,
    parameter int unsigned USER_WIDTH = 1
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axi4_stream_byte_packer.sv
// Combinational residue + input byte merge: yields the full word F, the new residue and total bytes.
module axi4_stream_byte_packer
    import axi4_stream_merge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8 * W,
    parameter int unsigned CNT_WIDTH  = BYTE_CNT_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]   i_res_data,
    input  logic [DATA_WIDTH/8-1:0] i_res_keep,
    input  logic [DATA_WIDTH/8-1:0] i_res_strb,
    input  logic [CNT_WIDTH-1:0]    i_res_cnt,
    input  logic [DATA_WIDTH-1:0]   i_in_data,
    input  logic [DATA_WIDTH/8-1:0] i_in_keep,
    input  logic [DATA_WIDTH/8-1:0] i_in_strb,
    input  logic [CNT_WIDTH-1:0]    i_in_cnt,
    output logic [CNT_WIDTH-1:0]    o_total,
    output logic [DATA_WIDTH-1:0]   o_f_data,
    output logic [DATA_WIDTH/8-1:0] o_f_keep,
    output logic [DATA_WIDTH/8-1:0] o_f_strb,
    output logic [DATA_WIDTH-1:0]   o_r_data,
    output logic [DATA_WIDTH/8-1:0] o_r_keep,
    output logic [DATA_WIDTH/8-1:0] o_r_strb,
    output logic [CNT_WIDTH-1:0]    o_r_cnt
);
    localparam int unsigned LP_W = DATA_WIDTH / 8;

    logic [2*DATA_WIDTH-1:0] w_res_ext;
    logic [2*DATA_WIDTH-1:0] w_in_ext;
    logic [2*DATA_WIDTH-1:0] w_c_data;
    logic [2*LP_W-1:0]       w_c_keep;
    logic [2*LP_W-1:0]       w_c_strb;
    logic                    w_full;

    // Zero invalid bytes so they cannot pollute neighbouring lanes after the shift.
    always_comb begin
        w_res_ext = '0;
        w_in_ext  = '0;
        for (int b = 0; b < LP_W; b++) begin
            w_res_ext[8*b +: 8] = i_res_keep[b] ? i_res_data[8*b +: 8] : 8'h00;
            w_in_ext[8*b +: 8]  = i_in_keep[b] ? i_in_data[8*b +: 8] : 8'h00;
        end
    end

    assign w_c_data = w_res_ext | (w_in_ext << {i_res_cnt, 3'b000});
    assign w_c_keep = {{LP_W{1'b0}}, i_res_keep} | ({{LP_W{1'b0}}, i_in_keep} << i_res_cnt);
    assign w_c_strb = {{LP_W{1'b0}}, i_res_strb & i_res_keep}
                    | ({{LP_W{1'b0}}, i_in_strb & i_in_keep} << i_res_cnt);

    assign o_total  = i_res_cnt + i_in_cnt;
    assign w_full   = (o_total >= CNT_WIDTH'(LP_W));

    assign o_f_data = w_c_data[DATA_WIDTH-1:0];
    assign o_f_keep = w_c_keep[LP_W-1:0];
    assign o_f_strb = w_c_strb[LP_W-1:0];
    assign o_r_data = w_full ? w_c_data[2*DATA_WIDTH-1:DATA_WIDTH] : w_c_data[DATA_WIDTH-1:0];
    assign o_r_keep = w_full ? w_c_keep[2*LP_W-1:LP_W] : w_c_keep[LP_W-1:0];
    assign o_r_strb = w_full ? w_c_strb[2*LP_W-1:LP_W] : w_c_strb[LP_W-1:0];
    assign o_r_cnt  = w_full ? o_total - CNT_WIDTH'(LP_W) : o_total;

endmodule

// File: rtl/axi4_stream_pkt_merge.sv
// Merges consecutive short AXI4-Stream packets into byte-packed longer ones, closing on
// byte threshold, tid/tdest change or idle timeout.
module axi4_stream_pkt_merge
    import axi4_stream_merge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8 * W,
    parameter int unsigned ID_WIDTH       = 1,
    parameter int unsigned DEST_WIDTH     = 1,
    parameter int unsigned USER_WIDTH     = 1,
    parameter int unsigned MAX_PKT_SIZE_B = 2048,
    parameter int unsigned PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B),
    parameter int unsigned TIMEOUT_WIDTH  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [PKT_SIZE_WIDTH:0]   flush_thresh_i,
    input  logic [TIMEOUT_WIDTH-1:0]  timeout_i,
    axi4_stream_if.slave              pkt_i,
    axi4_stream_if.master             pkt_o
);
    localparam int unsigned LP_W     = DATA_WIDTH / 8;
    localparam int unsigned LP_CNT_W = $clog2(LP_W) + 1;
    localparam int unsigned LP_OB_W  = PKT_SIZE_WIDTH + 1;

    state_e                  r_state;
    state_e                  w_state_next;

    logic [DATA_WIDTH-1:0]   r_h_data;
    logic [LP_W-1:0]         r_h_keep;
    logic [LP_W-1:0]         r_h_strb;
    logic                    r_h_valid;
    logic [DATA_WIDTH-1:0]   r_r_data;
    logic [LP_W-1:0]         r_r_keep;
    logic [LP_W-1:0]         r_r_strb;
    logic [LP_CNT_W-1:0]     r_res_cnt;
    logic [DATA_WIDTH-1:0]   r_o_data;
    logic [LP_W-1:0]         r_o_keep;
    logic [LP_W-1:0]         r_o_strb;
    logic                    r_o_valid;
    logic                    r_o_last;
    logic [LP_OB_W-1:0]      r_out_bytes;
    logic [TIMEOUT_WIDTH-1:0] r_idle_cnt;
    logic                    r_in_pkt;
    logic [ID_WIDTH-1:0]     r_tid;
    logic [DEST_WIDTH-1:0]   r_tdest;
    logic [USER_WIDTH-1:0]   r_tuser;

    logic [LP_CNT_W-1:0]     w_n;
    logic [LP_CNT_W-1:0]     w_total;
    logic [DATA_WIDTH-1:0]   w_f_data;
    logic [LP_W-1:0]         w_f_keep;
    logic [LP_W-1:0]         w_f_strb;
    logic [DATA_WIDTH-1:0]   w_nr_data;
    logic [LP_W-1:0]         w_nr_keep;
    logic [LP_W-1:0]         w_nr_strb;
    logic [LP_CNT_W-1:0]     w_nr_cnt;
    logic                    w_full;
    logic [LP_OB_W:0]        w_sum;
    logic [LP_OB_W-1:0]      w_bytes_next;
    logic                    w_thresh_hit;
    logic                    w_id_change;
    logic                    w_timeout;
    logic                    w_o_free;
    logic                    w_in_ready;
    logic                    w_in_fire;

    assign w_n = LP_CNT_W'(popcount_keep(KEEP_MAX'(pkt_i.tkeep)));

    axi4_stream_byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (LP_CNT_W)
    ) u_packer (
        .i_res_data (r_r_data),
        .i_res_keep (r_r_keep),
        .i_res_strb (r_r_strb),
        .i_res_cnt  (r_res_cnt),
        .i_in_data  (pkt_i.tdata),
        .i_in_keep  (pkt_i.tkeep),
        .i_in_strb  (pkt_i.tstrb),
        .i_in_cnt   (w_n),
        .o_total    (w_total),
        .o_f_data   (w_f_data),
        .o_f_keep   (w_f_keep),
        .o_f_strb   (w_f_strb),
        .o_r_data   (w_nr_data),
        .o_r_keep   (w_nr_keep),
        .o_r_strb   (w_nr_strb),
        .o_r_cnt    (w_nr_cnt)
    );

    assign w_full       = (w_total >= LP_CNT_W'(LP_W));
    assign w_sum        = {1'b0, r_out_bytes} + (LP_OB_W + 1)'(w_n);
    assign w_bytes_next = w_sum[LP_OB_W] ? '1 : w_sum[LP_OB_W-1:0];
    assign w_thresh_hit = (w_bytes_next >= flush_thresh_i);
    assign w_o_free     = !r_o_valid || pkt_o.tready;

    assign w_id_change  = (r_state == StMerge) && !r_in_pkt && pkt_i.tvalid
                       && ((pkt_i.tid != r_tid) || (pkt_i.tdest != r_tdest));
    // >= so a timeout enabled while already idle still fires.
    assign w_timeout    = (r_state == StMerge) && !r_in_pkt && (timeout_i != '0)
                       && (r_idle_cnt >= timeout_i);
    assign w_in_fire    = pkt_i.tvalid && w_in_ready;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_in_fire) begin
                    w_state_next = (pkt_i.tlast && w_thresh_hit) ? StFlush : StMerge;
                end
            end
            StMerge: begin
                if (w_in_fire && pkt_i.tlast && w_thresh_hit) begin
                    w_state_next = StFlush;
                end else if (w_id_change || w_timeout) begin
                    w_state_next = StFlush;
                end
            end
            StFlush: begin
                if (r_o_valid && pkt_o.tready && r_o_last) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_in_ready = (r_state != StFlush) && (!r_h_valid || w_o_free)
                  && !w_id_change && !w_timeout;
    end

    assign pkt_i.tready = w_in_ready;
    assign pkt_o.tvalid = r_o_valid;
    assign pkt_o.tdata  = r_o_data;
    assign pkt_o.tkeep  = r_o_keep;
    assign pkt_o.tstrb  = r_o_strb;
    assign pkt_o.tlast  = r_o_last;
    assign pkt_o.tid    = r_tid;
    assign pkt_o.tdest  = r_tdest;
    assign pkt_o.tuser  = r_tuser;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_h_data    <= '0;
            r_h_keep    <= '0;
            r_h_strb    <= '0;
            r_h_valid   <= 1'b0;
            r_r_data    <= '0;
            r_r_keep    <= '0;
            r_r_strb    <= '0;
            r_res_cnt   <= '0;
            r_o_data    <= '0;
            r_o_keep    <= '0;
            r_o_strb    <= '0;
            r_o_valid   <= 1'b0;
            r_o_last    <= 1'b0;
            r_out_bytes <= '0;
            r_idle_cnt  <= '0;
            r_in_pkt    <= 1'b0;
            r_tid       <= '0;
            r_tdest     <= '0;
            r_tuser     <= '0;
        end else begin
            if (r_o_valid && pkt_o.tready) begin
                r_o_valid <= 1'b0;
                if (r_o_last) begin
                    r_o_last    <= 1'b0;
                    r_out_bytes <= '0;
                end
            end

            if (w_in_fire) begin
                if (w_full) begin
                    if (r_h_valid) begin
                        r_o_data  <= r_h_data;
                        r_o_keep  <= r_h_keep;
                        r_o_strb  <= r_h_strb;
                        r_o_last  <= 1'b0;
                        r_o_valid <= 1'b1;
                    end
                    r_h_data  <= w_f_data;
                    r_h_keep  <= w_f_keep;
                    r_h_strb  <= w_f_strb;
                    r_h_valid <= 1'b1;
                end
                r_r_data    <= w_nr_data;
                r_r_keep    <= w_nr_keep;
                r_r_strb    <= w_nr_strb;
                r_res_cnt   <= w_nr_cnt;
                r_out_bytes <= w_bytes_next;
                r_in_pkt    <= !pkt_i.tlast;
                if (r_state == StIdle) begin
                    r_tid   <= pkt_i.tid;
                    r_tdest <= pkt_i.tdest;
                    r_tuser <= pkt_i.tuser;
                end
            end

            // Drain order while closing: H (last only if no residue), then the residue.
            if (r_state == StFlush && w_o_free) begin
                if (r_h_valid) begin
                    r_o_data  <= r_h_data;
                    r_o_keep  <= r_h_keep;
                    r_o_strb  <= r_h_strb;
                    r_o_last  <= (r_res_cnt == '0);
                    r_o_valid <= 1'b1;
                    r_h_valid <= 1'b0;
                end else if (r_res_cnt != '0) begin
                    r_o_data  <= r_r_data;
                    r_o_keep  <= r_r_keep;
                    r_o_strb  <= r_r_strb;
                    r_o_last  <= 1'b1;
                    r_o_valid <= 1'b1;
                    r_res_cnt <= '0;
                    r_r_keep  <= '0;
                    r_r_strb  <= '0;
                end
            end

            if (r_state == StMerge && !r_in_pkt && !w_in_fire) begin
                if (r_idle_cnt != '1) begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_stream_pkt_merge.sv
// Directed self-checking bench for axi4_stream_pkt_merge (W=4).
module tb_axi4_stream_pkt_merge;
    localparam int unsigned DW  = 32;
    localparam int unsigned PSW = 11;
    localparam int unsigned TW  = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [PSW:0]   thresh = 12'd16;
    logic [TW-1:0]  timeout = '0;
    logic           rdy_rand = 1'b0;
    logic           rdy_fixed = 1'b1;
    int             cyc = 0;
    int             last_acc = 0;
    int             n_tests = 0;
    int             n_fail = 0;

    logic [31:0]    mon_data[$];
    logic [3:0]     mon_keep[$];
    logic [3:0]     mon_strb[$];
    logic           mon_last[$];
    logic           mon_tid[$];
    int             mon_cyc[$];
    logic [7:0]     got_bytes[$];

    axi4_stream_if #(.DATA_WIDTH(DW), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) s_if ();
    axi4_stream_if #(.DATA_WIDTH(DW), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) m_if ();

    axi4_stream_pkt_merge #(
        .DATA_WIDTH     (DW),
        .ID_WIDTH       (1),
        .DEST_WIDTH     (1),
        .USER_WIDTH     (1),
        .MAX_PKT_SIZE_B (2048),
        .PKT_SIZE_WIDTH (PSW),
        .TIMEOUT_WIDTH  (TW)
    ) u_dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .flush_thresh_i (thresh),
        .timeout_i      (timeout),
        .pkt_i          (s_if),
        .pkt_o          (m_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        m_if.tready = rdy_rand ? 1'($urandom_range(1, 0)) : rdy_fixed;
    end

    // Beats seen valid&ready at the negedge handshake on the following posedge.
    always @(negedge clk) begin
        if (rst_n && m_if.tvalid && m_if.tready) begin
            mon_data.push_back(m_if.tdata);
            mon_keep.push_back(m_if.tkeep);
            mon_strb.push_back(m_if.tstrb);
            mon_last.push_back(m_if.tlast);
            mon_tid.push_back(m_if.tid);
            mon_cyc.push_back(cyc);
            for (int b = 0; b < 4; b++) begin
                if (m_if.tkeep[b]) got_bytes.push_back(m_if.tdata[8*b +: 8]);
            end
        end
    end

    task automatic clear_mon();
        mon_data.delete(); mon_keep.delete(); mon_strb.delete();
        mon_last.delete(); mon_tid.delete(); mon_cyc.delete(); got_bytes.delete();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic t);
        int w;
        s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tkeep = k; s_if.tstrb = k;
        s_if.tlast = l; s_if.tid = t; s_if.tdest = 1'b0; s_if.tuser = 1'b0;
        w = 0;
        while (1) begin
            @(negedge clk);
            if (s_if.tready) break;
            w++;
            if (w >= 500) begin
                n_tests++; n_fail++;
                $display("FAIL send_beat: tready stuck low for %0d cycles, expected a handshake", w);
                break;
            end
        end
        @(posedge clk); #1;
        last_acc = cyc;
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic t, input int base);
        int nb;
        logic [31:0] d;
        logic [3:0] k;
        for (int o = 0; o < len; o += 4) begin
            nb = (len - o > 4) ? 4 : len - o;
            d = 32'hEEEE_EEEE;
            for (int j = 0; j < nb; j++) d[8*j +: 8] = 8'(base + o + j);
            k = 4'((1 << nb) - 1);
            send_beat(d, k, (o + 4 >= len), t);
        end
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int w;
        w = 0;
        while (mon_data.size() < n && w < budget) begin
            @(posedge clk); w++;
        end
        #1;
        if (mon_data.size() < n) begin
            n_tests++; n_fail++;
            $display("FAIL %s: got %0d output beats, expected %0d", name, mon_data.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tstrb = '0;
        s_if.tlast = 1'b0; s_if.tid = '0; s_if.tdest = '0; s_if.tuser = '0;
        idle_cycles(3);
        n_tests++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", m_if.tvalid); end
        n_tests++; if (m_if.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b expected 0", m_if.tlast); end
        n_tests++; if (m_if.tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata: got %h expected 0", m_if.tdata); end
        n_tests++; if (m_if.tkeep !== 4'h0) begin n_fail++; $display("FAIL reset_tkeep: got %h expected 0", m_if.tkeep); end
        rst_n = 1'b1;
        idle_cycles(2);
        n_tests++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %b expected 1", s_if.tready); end
    endtask

    // Four 4-byte packets, threshold 16 -> one 4-beat packet.
    task automatic test_back_to_back();
        logic [31:0] e;
        thresh = 12'd16; timeout = '0; clear_mon();
        for (int p = 0; p < 4; p++) send_pkt(4, 1'b0, 16 + 4 * p);
        wait_beats(4, 100, "b2b_beats");
        idle_cycles(5);
        n_tests++; if (mon_data.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d beats expected 4", mon_data.size()); end
        for (int i = 0; i < 4 && i < mon_data.size(); i++) begin
            for (int j = 0; j < 4; j++) e[8*j +: 8] = 8'(16 + 4 * i + j);
            n_tests++; if (mon_data[i] !== e) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, mon_data[i], e); end
            n_tests++; if (mon_keep[i] !== 4'hF) begin n_fail++; $display("FAIL b2b_keep[%0d]: got %h expected f", i, mon_keep[i]); end
            n_tests++; if (mon_strb[i] !== 4'hF) begin n_fail++; $display("FAIL b2b_strb[%0d]: got %h expected f", i, mon_strb[i]); end
            n_tests++; if (mon_last[i] !== (i == 3)) begin n_fail++; $display("FAIL b2b_last[%0d]: got %b expected %b", i, mon_last[i], i == 3); end
        end
    endtask

    // 3+3+3 bytes, threshold 8 -> beats F,F,1 with contiguous bytes 0x20..0x28.
    task automatic test_partial_pack();
        logic [31:0] ed[3];
        logic [3:0]  ek[3];
        logic [31:0] msk;
        thresh = 12'd8; timeout = '0; clear_mon();
        ed[0] = 32'h23222120; ed[1] = 32'h27262524; ed[2] = 32'h00000028;
        ek[0] = 4'hF; ek[1] = 4'hF; ek[2] = 4'h1;
        send_pkt(3, 1'b0, 8'h20);
        send_pkt(3, 1'b0, 8'h23);
        send_pkt(3, 1'b0, 8'h26);
        wait_beats(3, 100, "pack_beats");
        idle_cycles(5);
        n_tests++; if (mon_data.size() != 3) begin n_fail++; $display("FAIL pack_count: got %0d beats expected 3", mon_data.size()); end
        for (int i = 0; i < 3 && i < mon_data.size(); i++) begin
            for (int j = 0; j < 4; j++) msk[8*j +: 8] = {8{ek[i][j]}};
            n_tests++; if ((mon_data[i] & msk) !== ed[i]) begin n_fail++; $display("FAIL pack_data[%0d]: got %h expected %h", i, mon_data[i] & msk, ed[i]); end
            n_tests++; if (mon_keep[i] !== ek[i]) begin n_fail++; $display("FAIL pack_keep[%0d]: got %h expected %h", i, mon_keep[i], ek[i]); end
            n_tests++; if (mon_last[i] !== (i == 2)) begin n_fail++; $display("FAIL pack_last[%0d]: got %b expected %b", i, mon_last[i], i == 2); end
        end
    endtask

    // tid 0 (5 B) closed by the tid 1 beat; tid 1 (2 B) closed by timeout.
    task automatic test_id_change();
        int c1;
        thresh = 12'd64; timeout = 16'd8; clear_mon();
        send_pkt(5, 1'b0, 8'h30);
        send_pkt(2, 1'b1, 8'h40);
        c1 = last_acc;
        wait_beats(3, 100, "idc_beats");
        idle_cycles(5);
        n_tests++; if (mon_data.size() != 3) begin n_fail++; $display("FAIL idc_count: got %0d beats expected 3", mon_data.size()); end
        if (mon_data.size() >= 3) begin
            n_tests++; if (mon_data[0] !== 32'h33323130 || mon_keep[0] !== 4'hF || mon_last[0] !== 1'b0 || mon_tid[0] !== 1'b0) begin n_fail++; $display("FAIL idc_beat0: got d=%h k=%h l=%b id=%b expected d=33323130 k=f l=0 id=0", mon_data[0], mon_keep[0], mon_last[0], mon_tid[0]); end
            n_tests++; if (mon_data[1][7:0] !== 8'h34 || mon_keep[1] !== 4'h1 || mon_last[1] !== 1'b1 || mon_tid[1] !== 1'b0) begin n_fail++; $display("FAIL idc_beat1: got d=%h k=%h l=%b id=%b expected d=..34 k=1 l=1 id=0", mon_data[1], mon_keep[1], mon_last[1], mon_tid[1]); end
            n_tests++; if (mon_data[2][15:0] !== 16'h4140 || mon_keep[2] !== 4'h3 || mon_last[2] !== 1'b1 || mon_tid[2] !== 1'b1) begin n_fail++; $display("FAIL idc_beat2: got d=%h k=%h l=%b id=%b expected d=..4140 k=3 l=1 id=1", mon_data[2], mon_keep[2], mon_last[2], mon_tid[2]); end
            n_tests++; if (!(mon_cyc[1] < c1)) begin n_fail++; $display("FAIL idc_order: tid0 tlast at cycle %0d, tid1 accepted at %0d, expected tlast first", mon_cyc[1] + 1, c1); end
        end
    endtask

    // Timeout 10: beat0 at +12, tlast beat at +13 cycles from the input tlast handshake.
    task automatic test_timeout();
        int c0;
        thresh = 12'd64; timeout = 16'd10; clear_mon();
        send_pkt(6, 1'b0, 8'h50);
        c0 = last_acc;
        wait_beats(2, 100, "to_beats");
        idle_cycles(5);
        n_tests++; if (mon_data.size() != 2) begin n_fail++; $display("FAIL to_count: got %0d beats expected 2", mon_data.size()); end
        if (mon_data.size() >= 2) begin
            n_tests++; if (mon_data[0] !== 32'h53525150 || mon_last[0] !== 1'b0) begin n_fail++; $display("FAIL to_beat0: got d=%h l=%b expected d=53525150 l=0", mon_data[0], mon_last[0]); end
            n_tests++; if (mon_data[1][15:0] !== 16'h5554 || mon_keep[1] !== 4'h3 || mon_last[1] !== 1'b1) begin n_fail++; $display("FAIL to_beat1: got d=%h k=%h l=%b expected d=..5554 k=3 l=1", mon_data[1], mon_keep[1], mon_last[1]); end
            n_tests++; if (mon_cyc[0] - c0 != 12) begin n_fail++; $display("FAIL to_lat0: got %0d cycles expected 12", mon_cyc[0] - c0); end
            n_tests++; if (mon_cyc[1] - c0 != 13) begin n_fail++; $display("FAIL to_lat1: got %0d cycles expected 13", mon_cyc[1] - c0); end
        end
        timeout = '0;
    endtask

    task automatic test_random_stream();
        logic [7:0] exp_bytes[$];
        int exp_len[$];
        int got_len[$];
        int acc, len, base, w, bad, part, pl, kc;
        thresh = 12'd32; timeout = '0; clear_mon();
        rdy_rand = 1'b1;
        acc = 0;
        for (int p = 0; p < 1000; p++) begin
            len = $urandom_range(40, 1);
            base = int'($urandom_range(255, 0));
            for (int i = 0; i < len; i++) exp_bytes.push_back(8'(base + i));
            acc += len;
            if (acc >= 32) begin exp_len.push_back(acc); acc = 0; end
            send_pkt(len, 1'b0, base);
        end
        if (acc > 0) exp_len.push_back(acc);
        timeout = 16'd5;
        w = 0;
        while (got_bytes.size() < exp_bytes.size() && w < 3000) begin @(posedge clk); w++; end
        idle_cycles(20);
        rdy_rand = 1'b0;
        n_tests++; if (got_bytes.size() != exp_bytes.size()) begin n_fail++; $display("FAIL rnd_bytecount: got %0d expected %0d", got_bytes.size(), exp_bytes.size()); end
        bad = 0;
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) if (got_bytes[i] !== exp_bytes[i]) bad++;
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rnd_bytes: got %0d mismatching bytes expected 0", bad); end
        part = 0; pl = 0;
        for (int i = 0; i < mon_keep.size(); i++) begin
            kc = 0;
            for (int b = 0; b < 4; b++) kc += int'(mon_keep[i][b]);
            if (!mon_last[i] && mon_keep[i] !== 4'hF) part++;
            pl += kc;
            if (mon_last[i]) begin got_len.push_back(pl); pl = 0; end
        end
        n_tests++; if (part != 0) begin n_fail++; $display("FAIL rnd_partial: got %0d partial non-last beats expected 0", part); end
        n_tests++; if (got_len.size() != exp_len.size()) begin n_fail++; $display("FAIL rnd_pktcount: got %0d packets expected %0d", got_len.size(), exp_len.size()); end
        bad = 0;
        for (int i = 0; i < exp_len.size() && i < got_len.size(); i++) if (got_len[i] != exp_len[i]) bad++;
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rnd_pktlen: got %0d wrong packet lengths expected 0", bad); end
        timeout = '0;
    endtask

    task automatic test_reset_mid_flush();
        thresh = 12'd4; timeout = '0; rdy_fixed = 1'b0;
        idle_cycles(2);
        clear_mon();
        send_pkt(4, 1'b0, 8'h60);
        idle_cycles(3);
        @(negedge clk);
        n_tests++; if (m_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL rstf_pre: got tvalid %b expected 1", m_if.tvalid); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL rstf_tvalid: got %b expected 0", m_if.tvalid); end
        n_tests++; if (m_if.tlast !== 1'b0) begin n_fail++; $display("FAIL rstf_tlast: got %b expected 0", m_if.tlast); end
        @(posedge clk); #1;
        rst_n = 1'b1; rdy_fixed = 1'b1; thresh = 12'd8;
        idle_cycles(2);
        clear_mon();
        send_pkt(4, 1'b0, 8'h70);
        send_pkt(4, 1'b0, 8'h74);
        wait_beats(2, 100, "rstf_beats");
        idle_cycles(5);
        n_tests++; if (mon_data.size() != 2) begin n_fail++; $display("FAIL rstf_count: got %0d beats expected 2", mon_data.size()); end
        if (mon_data.size() >= 2) begin
            n_tests++; if (mon_data[0] !== 32'h73727170 || mon_last[0] !== 1'b0) begin n_fail++; $display("FAIL rstf_beat0: got d=%h l=%b expected d=73727170 l=0", mon_data[0], mon_last[0]); end
            n_tests++; if (mon_data[1] !== 32'h77767574 || mon_last[1] !== 1'b1) begin n_fail++; $display("FAIL rstf_beat1: got d=%h l=%b expected d=77767574 l=1", mon_data[1], mon_last[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_partial_pack();
        test_id_change();
        test_timeout();
        test_random_stream();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
